hex_record_formatter: RTL and testbench

HEX_RECORD_FORMATTER -- requirements
Module: hex_record_formatter

---
 rtl/hex_record_formatter.sv | 99 +++++++++
 tb/tb_hex_record_formatter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_record_formatter.sv
// hex_record_formatter: formats LPC records (ext_clock, reset, rec_*) as ASCII hex lines on a tx_data/tx_valid/tx_ready stream with busy; HEX_RECORD_FORMATTER_DROP_COUNT_EN adds drop_count
module hex_record_formatter #(
  parameter int HEX_UPPER = 1,
  parameter int EOL_CRLF = 1
) (
  input  logic        ext_clock,
  input  logic        reset,
  input  logic        rec_strobe,
  input  logic        rec_write,
  input  logic [15:0] rec_addr,
  input  logic [7:0]  rec_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
  ,
  output logic [7:0]  drop_count
`endif
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [3:0] LAST_IDX = (EOL_CRLF != 0) ? 4'd10 : 4'd9;
  state_t state, state_n;
  logic [24:0] act, act_n, hold, hold_n, in_rec;
  logic hold_full, hold_full_n, xfer, last;
  logic [3:0] idx, idx_n;
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : ((HEX_UPPER != 0) ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction
  assign in_rec = {rec_write, rec_addr, rec_data};
  assign tx_valid = state == EMIT;
  assign busy = tx_valid | hold_full;
  assign xfer = tx_valid & tx_ready;
  assign last = xfer & (idx == LAST_IDX);
  always_comb begin
    state_n = state;
    idx_n = idx;
    act_n = act;
    hold_n = hold;
    hold_full_n = hold_full;
    if (state == IDLE) begin
      if (rec_strobe) begin
        act_n = in_rec;
        idx_n = 4'd0;
        state_n = EMIT;
      end
    end else if (last) begin
      idx_n = 4'd0;
      if (hold_full) begin
        act_n = hold;
        hold_n = in_rec;
        hold_full_n = rec_strobe;
      end else if (rec_strobe) act_n = in_rec;
      else state_n = IDLE;
    end else begin
      idx_n = xfer ? idx + 4'd1 : idx;
      if (rec_strobe && !hold_full) begin
        hold_n = in_rec;
        hold_full_n = 1'b1;
      end
    end
  end
  always_ff @(posedge ext_clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= 4'd0;
      hold_full <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      hold_full <= hold_full_n;
      act <= act_n;
      hold <= hold_n;
    end
  end
  always_comb begin
    tx_data = 8'h00;
    if (state == EMIT)
      case (idx)
        4'd0: tx_data = act[24] ? 8'h57 : 8'h52;
        4'd1, 4'd6: tx_data = 8'h20;
        4'd2: tx_data = hex_char(act[23:20]);
        4'd3: tx_data = hex_char(act[19:16]);
        4'd4: tx_data = hex_char(act[15:12]);
        4'd5: tx_data = hex_char(act[11:8]);
        4'd7: tx_data = hex_char(act[7:4]);
        4'd8: tx_data = hex_char(act[3:0]);
        4'd9: tx_data = (EOL_CRLF != 0) ? 8'h0D : 8'h0A;
        default: tx_data = 8'h0A;
      endcase
  end
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
  always_ff @(posedge ext_clock) begin
    if (reset) drop_count <= 8'h00;
    else if (rec_strobe && state == EMIT && hold_full && !last && drop_count != 8'hff)
      drop_count <= drop_count + 8'h01;
  end
`endif
endmodule

// File: tb/tb_hex_record_formatter.sv
// tb_hex_record_formatter: table vectors, corner sequences and a random run checked against a record-queue model
module tb_hex_record_formatter;
  typedef struct packed {logic w; logic [15:0] a; logic [7:0] d;} rec_t;
  typedef logic [7:0] bq_t[$];
  typedef struct {logic w; logic [15:0] a; logic [7:0] d; logic [87:0] exp;} vec_t;
  logic ext_clock = 0, reset = 1, rec_strobe = 0, rec_write = 0, tx_ready = 1;
  logic [15:0] rec_addr = 0;
  logic [7:0] rec_data = 0;
  logic [7:0] tx_data;
  logic tx_valid, busy;
  logic s2 = 0, w2 = 0;
  logic [15:0] a2 = 0;
  logic [7:0] d2 = 0, tx_data2;
  logic tx_valid2, busy2;
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
  logic [7:0] drop_count, drop_count2;
`endif
  int n_pass = 0, n_total = 0, pos = 0, dc = 0;
  rec_t q[$];
  bq_t col, col2;
  vec_t tbl[4];
  always #5 ext_clock = ~ext_clock;
  hex_record_formatter dut (
    .ext_clock(ext_clock), .reset(reset), .rec_strobe(rec_strobe), .rec_write(rec_write),
    .rec_addr(rec_addr), .rec_data(rec_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );
  hex_record_formatter #(.HEX_UPPER(0), .EOL_CRLF(0)) dut2 (
    .ext_clock(ext_clock), .reset(reset), .rec_strobe(s2), .rec_write(w2),
    .rec_addr(a2), .rec_data(d2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(1'b1), .busy(busy2)
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
    , .drop_count(drop_count2)
`endif
  );
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    return (n < 10) ? 8'd48 + n : (up ? 8'd65 : 8'd97) + n - 8'd10;
  endfunction
  function automatic bq_t mk_line(input rec_t r, input bit up, input bit crlf);
    bq_t s;
    s.push_back(r.w ? "W" : "R");
    s.push_back(" ");
    for (int i = 3; i >= 0; i--) s.push_back(hexc(r.a[i*4 +: 4], up));
    s.push_back(" ");
    s.push_back(hexc(r.d[7:4], up));
    s.push_back(hexc(r.d[3:0], up));
    if (crlf) s.push_back(8'h0D);
    s.push_back(8'h0A);
    return s;
  endfunction
  function automatic bq_t cat(input bq_t a, input bq_t b);
    foreach (b[i]) a.push_back(b[i]);
    return a;
  endfunction
  function automatic logic [95:0] pack(input bq_t s);
    logic [95:0] v = 0;
    foreach (s[i]) v = {v[87:0], s[i]};
    return v;
  endfunction
  // Model: accepted records wait in a queue of at most two (one being printed, one held)
  always @(negedge ext_clock) begin
    bq_t ln;
    bit ev;
    ev = q.size() > 0;
    chk("tx_valid", tx_valid, ev);
    chk("busy", busy, ev);
    if (ev) begin
      ln = mk_line(q[0], 1, 1);
      chk("tx_data", tx_data, ln[pos]);
    end
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
    chk("drop_count", drop_count, dc);
`endif
    if (tx_valid && tx_ready) col.push_back(tx_data);
    if (tx_valid2) col2.push_back(tx_data2);
    if (reset) begin
      q.delete();
      pos = 0;
      dc = 0;
    end else begin
      if (ev && tx_ready) begin
        pos++;
        if (pos == ln.size()) begin
          void'(q.pop_front());
          pos = 0;
        end
      end
      if (rec_strobe) begin
        if (q.size() < 2) q.push_back({rec_write, rec_addr, rec_data});
        else if (dc < 255) dc++;
      end
    end
  end
  task automatic tick;
    @(posedge ext_clock);
    #1;
  endtask
  task automatic strobe(input logic w, input logic [15:0] a, input logic [7:0] d);
    rec_strobe = 1;
    rec_write = w;
    rec_addr = a;
    rec_data = d;
    tick();
    rec_strobe = 0;
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  task automatic pulse_reset;
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic chk_col(input string nm, input bq_t e);
    chk({nm, "_len"}, col.size(), e.size());
    chk(nm, pack(col), pack(e));
  endtask
  initial begin
    bq_t e;
    int n;
    tbl[0] = '{1'b1, 16'h0024, 8'hA5, 88'h57_20_30_30_32_34_20_41_35_0D_0A};
    tbl[1] = '{1'b0, 16'hFFFF, 8'h00, 88'h52_20_46_46_46_46_20_30_30_0D_0A};
    tbl[2] = '{1'b1, 16'h1234, 8'h9F, 88'h57_20_31_32_33_34_20_39_46_0D_0A};
    tbl[3] = '{1'b0, 16'hABCD, 8'h5E, 88'h52_20_41_42_43_44_20_35_45_0D_0A};
    repeat (3) tick();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      col.delete();
      strobe(tbl[i].w, tbl[i].a, tbl[i].d);
      wait_idle();
      chk($sformatf("tbl%0d_len", i), col.size(), 11);
      chk($sformatf("tbl%0d_line", i), pack(col), {8'h0, tbl[i].exp});
    end
    s2 = 1; w2 = 0; a2 = 16'hBEEF; d2 = 8'h0C;
    tick();
    s2 = 0;
    repeat (15) tick();
    chk("lower_lf_len", col2.size(), 10);
    chk("lower_lf_line", pack(col2), {16'h0, 80'h52_20_62_65_65_66_20_30_63_0A});
    chk("lower_lf_busy", busy2, 0);
    col.delete();
    strobe(1, 16'h0024, 8'hA5);
    for (int i = 0; i < 60; i++) begin
      tx_ready = (i % 3 == 0);
      tick();
    end
    tx_ready = 1;
    wait_idle();
    chk_col("ready_toggle", mk_line('{1'b1, 16'h0024, 8'hA5}, 1, 1));
    pulse_reset();
    col.delete();
    strobe(1, 16'h1111, 8'h22);
    tick();
    strobe(0, 16'h3333, 8'h44);
    tick();
    strobe(1, 16'h5555, 8'h66);
    wait_idle();
    chk_col("three_strobes", cat(mk_line('{1'b1, 16'h1111, 8'h22}, 1, 1), mk_line('{1'b0, 16'h3333, 8'h44}, 1, 1)));
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
    chk("one_drop", drop_count, 1);
`endif
    pulse_reset();
    tx_ready = 0;
    rec_strobe = 1;
    for (int i = 0; i < 300; i++) begin
      rec_addr = 16'($urandom);
      tick();
    end
    rec_strobe = 0;
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
    chk("drop_saturate", drop_count, 255);
`endif
    tx_ready = 1;
    wait_idle();
    pulse_reset();
    col.delete();
    strobe(0, 16'hC0DE, 8'h01);
    tick();
    strobe(1, 16'h0F0F, 8'hE7);
    n = 0;
    while (!(tx_valid && tx_data == 8'h0A) && n < 30) begin
      tick();
      n++;
    end
    chk("lf_wait_timeout", n < 30, 1);
    strobe(0, 16'h7A7A, 8'h3C);
    wait_idle();
    e = cat(mk_line('{1'b0, 16'hC0DE, 8'h01}, 1, 1), mk_line('{1'b1, 16'h0F0F, 8'hE7}, 1, 1));
    chk_col("strobe_on_lf", cat(e, mk_line('{1'b0, 16'h7A7A, 8'h3C}, 1, 1)));
`ifdef HEX_RECORD_FORMATTER_DROP_COUNT_EN
    chk("strobe_on_lf_drop", drop_count, 0);
`endif
    col.delete();
    strobe(1, 16'h9999, 8'h99);
    strobe(0, 16'h8888, 8'h88);
    n = 0;
    while (col.size() < 5 && n < 30) begin
      tick();
      n++;
    end
    chk("char5_timeout", col.size(), 5);
    reset = 1;
    tick();
    chk("midline_rst_valid", tx_valid, 0);
    chk("midline_rst_busy", busy, 0);
    rec_strobe = 1;
    tick();
    rec_strobe = 0;
    reset = 0;
    col.delete();
    repeat (20) tick();
    chk("abandoned_silent", col.size(), 0);
    strobe(0, 16'h1357, 8'h24);
    wait_idle();
    chk_col("fresh_line", mk_line('{1'b0, 16'h1357, 8'h24}, 1, 1));
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 300 == 0);
      rec_strobe = ($urandom % 6 == 0);
      rec_write = 1'($urandom);
      rec_addr = 16'($urandom);
      rec_data = 8'($urandom);
      tx_ready = ($urandom % 4 != 0);
      tick();
    end
    reset = 0;
    rec_strobe = 0;
    tx_ready = 1;
    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
